sliding_avg_mc: RTL and testbench

Multi-channel, runtime-configurable sliding (boxcar) average filter with input decimation, intended for the ADC subsystem between the sample capture stage and downstream measurement logic. All channels share one valid strobe and are filtered in lockstep with independent accumulators. The window length is a power of two selectable at run time up to a compile-time maximum. Division uses rounding rather than truncation, and a primed flag marks when the window has filled.

---
 rtl/sliding_avg_mc.sv | 148 ++++++++++++++
 tb/tb_sliding_avg_mc.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sliding_avg_mc.sv
// sliding_avg_mc: multi-channel power-of-two boxcar average with decimation.
// Ports: clk/rst, i_data/i_valid samples, i_win_log2, i_sample_interval,
//        i_clear flush; o_data averages, o_valid strobe, o_primed window-full.
module sliding_avg_mc #(
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_WIN_LOG2 = 10,
  parameter int NUM_CH       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  input  logic                         i_valid,
  input  logic [3:0]                   i_win_log2,
  input  logic [7:0]                   i_sample_interval,
  input  logic                         i_clear,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  output logic                         o_primed
);

  localparam int DW    = DATA_WIDTH;
  localparam int AW    = MAX_WIN_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam int SW    = DW + AW;
  localparam int FW    = AW + 1;
  localparam logic [3:0] KMAX = 4'(MAX_WIN_LOG2);

  logic flush;
  assign flush = rst | i_clear;

  logic [3:0]    k_q;
  logic [FW-1:0] win_len;
  assign win_len = FW'(1) << k_q;

  // decimator + accept register
  logic [7:0]             dec_cnt;
  logic [8:0]             dec_nxt;
  logic                   accept;
  logic                   s1_v;
  logic [NUM_CH*DW-1:0]   s1_d;

  assign dec_nxt = {1'b0, dec_cnt} + 9'd1;
  // >= also covers N of 0/1 and N lowered below the running count
  assign accept  = i_valid & (dec_nxt >= {1'b0, i_sample_interval});

  always_ff @(posedge clk) begin
    if (flush) begin
      k_q     <= (i_win_log2 > KMAX) ? KMAX : i_win_log2;
      dec_cnt <= '0;
      s1_v    <= 1'b0;
      s1_d    <= '0;
    end else begin
      s1_v <= accept;
      if (i_valid)
        dec_cnt <= accept ? '0 : dec_nxt[7:0];
      if (accept)
        s1_d <= i_data;
    end
  end

  // ram stage bookkeeping
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_addr;
  logic [FW-1:0]        fill;
  logic                 s2_v;
  logic                 s2_fill;
  logic                 s2_last;
  logic [NUM_CH*DW-1:0] s2_d;

  // full-depth window truncates L to 0, so read and write share an address
  assign rd_addr = wr_ptr - win_len[AW-1:0];

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr  <= '0;
      fill    <= '0;
      s2_v    <= 1'b0;
      s2_fill <= 1'b0;
      s2_last <= 1'b0;
      s2_d    <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        wr_ptr  <= wr_ptr + AW'(1);
        s2_fill <= (fill != win_len);
        s2_last <= (fill >= win_len - FW'(1));
        s2_d    <= s1_d;
        if (fill != win_len)
          fill <= fill + FW'(1);
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic        [DW-1:0] ram [DEPTH];
    logic        [DW-1:0] rd_q;
    logic        [DW-1:0] avg_q;
    logic        [DW-1:0] avg_nxt;
    logic signed [SW-1:0] sum_q;
    logic signed [SW-1:0] sum_nxt;
    logic signed [SW-1:0] new_x;
    logic signed [SW-1:0] old_x;
    logic signed [SW:0]   bias;
    logic signed [SW:0]   biased;

    // read-first: rd_q returns the old word on a coincident address
    always_ff @(posedge clk) begin
      if (s1_v) begin
        ram[wr_ptr] <= s1_d[c*DW +: DW];
        rd_q        <= ram[rd_addr];
      end
    end

    // unfilled window: stale ram never reaches the sum
    assign new_x   = SW'($signed(s2_d[c*DW +: DW]));
    assign old_x   = s2_fill ? '0 : SW'($signed(rd_q));
    assign sum_nxt = sum_q + new_x - old_x;

    assign bias    = (k_q == 4'd0) ? '0
                   : ((SW+1)'(1) << (k_q - 4'd1));
    assign biased  = {sum_nxt[SW-1], sum_nxt} + bias;
    assign avg_nxt = DW'(biased >>> k_q);

    always_ff @(posedge clk) begin
      if (flush) begin
        sum_q <= '0;
        avg_q <= '0;
      end else if (s2_v) begin
        sum_q <= sum_nxt;
        avg_q <= avg_nxt;
      end
    end

    assign o_data[c*DW +: DW] = avg_q;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      o_valid  <= 1'b0;
      o_primed <= 1'b0;
    end else begin
      o_valid <= s2_v;
      if (s2_v && s2_last)
        o_primed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sliding_avg_mc.sv
// tb_sliding_avg_mc: directed stimulus against a queue-based window model.
// Every cycle compares o_valid/o_data/o_primed; literal checks pin the model.
module tb_sliding_avg_mc;

  localparam int DW   = 16;
  localparam int NCH  = 2;
  localparam int MAXK = 10;
  localparam int PW   = DW * NCH;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] i_data;
  logic          i_valid;
  logic [3:0]    i_win_log2;
  logic [7:0]    i_sample_interval;
  logic          i_clear;
  logic [PW-1:0] o_data;
  logic          o_valid;
  logic          o_primed;

  sliding_avg_mc #(
    .DATA_WIDTH(DW),
    .MAX_WIN_LOG2(MAXK),
    .NUM_CH(NCH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_data(i_data),
    .i_valid(i_valid),
    .i_win_log2(i_win_log2),
    .i_sample_interval(i_sample_interval),
    .i_clear(i_clear),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_primed(o_primed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int            due;
    logic [PW-1:0] data;
    bit            primed;
  } exp_t;

  exp_t          q[$];
  int            hist [NCH][$];
  int            k_m = 0;
  int            cnt_m = 0;
  int            nacc = 0;
  int            clear_at = -1;
  bit            chk_en = 1'b0;
  logic [PW-1:0] exp_d = '0;
  bit            exp_p = 1'b0;
  logic [PW-1:0] got[$];
  bit            gotp[$];

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [PW-1:0] pk(int a, int b);
    return {16'(b), 16'(a)};
  endfunction

  // window = last L accepted samples; avg = floor((sum + L/2) / L)
  function automatic void model_accept(logic [PW-1:0] d);
    exp_t   e;
    longint s;
    int     len = 1 << k_m;
    e.data = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      hist[ch].push_back(int'($signed(d[ch*DW +: DW])));
      if (hist[ch].size() > len)
        void'(hist[ch].pop_front());
      s = 0;
      for (int i = 0; i < hist[ch].size(); i++)
        s += hist[ch][i];
      if (k_m > 0)
        s = (s + (longint'(1) << (k_m - 1))) >>> k_m;
      e.data[ch*DW +: DW] = s[DW-1:0];
    end
    nacc++;
    e.primed = (nacc >= len);
    e.due = cyc + 3;
    q.push_back(e);
  endfunction

  task automatic step(bit r, bit c, bit v, logic [PW-1:0] d);
    rst = r;
    i_clear = c;
    i_valid = v;
    i_data = d;
    if (r || c) begin
      k_m = (i_win_log2 > MAXK) ? MAXK : int'(i_win_log2);
      cnt_m = 0;
      nacc = 0;
      for (int ch = 0; ch < NCH; ch++)
        hist[ch].delete();
      while (q.size() > 0 && q[$].due > cyc)
        void'(q.pop_back());
      clear_at = cyc + 1;
    end else if (v) begin
      int nn;
      nn = (i_sample_interval <= 1) ? 1 : int'(i_sample_interval);
      if (cnt_m + 1 >= nn) begin
        cnt_m = 0;
        model_accept(d);
      end else begin
        cnt_m++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, '0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit due;
      if (cyc == clear_at) begin
        exp_d = '0;
        exp_p = 1'b0;
      end
      due = (q.size() > 0) && (q[0].due == cyc);
      if (due) begin
        exp_d = q[0].data;
        exp_p = q[0].primed;
        void'(q.pop_front());
      end
      chk("o_valid", 64'(o_valid), 64'(due));
      chk("o_data", 64'(o_data), 64'(exp_d));
      chk("o_primed", 64'(o_primed), 64'(exp_p));
      if (o_valid === 1'b1) begin
        got.push_back(o_data);
        gotp.push_back(o_primed);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int fill_v [6] = '{25, 50, 75, 100, 100, 100};
  int rnd_in [5] = '{1, 2, -2, -3, -32768};
  int rnd_ex [5] = '{0, 1, 0, -1, -32768};
  int dec_ex [4] = '{1, 2, 4, 7};

  initial begin
    rst = 1'b1;
    i_clear = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    i_win_log2 = 4'd2;
    i_sample_interval = 8'd1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, '0);
    chk_en = 1'b1;
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_data", 64'(o_data), 64'(0));
    chk("rst_primed", 64'(o_primed), 64'(0));

    // constant fill, k=2
    step(1'b0, 1'b1, 1'b0, '0);
    got.delete(); gotp.delete();
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 1'b1, pk(100, 0));
    idle(4);
    chk("fill_cnt", 64'(got.size()), 64'(6));
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      chk("fill_val", 64'($signed(got[i][15:0])), 64'(fill_v[i]));
      chk("fill_prm", 64'(gotp[i]), 64'(i >= 3));
    end

    // rounding and sign
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      got.delete(); gotp.delete();
      for (int j = 0; j < 4; j++)
        step(1'b0, 1'b0, 1'b1,
             pk((i == 4 || j == 0) ? rnd_in[i] : 0, 0));
      idle(4);
      chk("rnd_cnt", 64'(got.size()), 64'(4));
      if (got.size() == 4)
        chk("rnd_val", 64'($signed(got[3][15:0])), 64'(rnd_ex[i]));
    end

    // decimation N=3
    i_sample_interval = 8'd3;
    step(1'b0, 1'b1, 1'b0, '0);
    got.delete(); gotp.delete();
    for (int v = 0; v < 12; v++)
      step(1'b0, 1'b0, 1'b1, pk(v, 0));
    idle(4);
    chk("dec_cnt", 64'(got.size()), 64'(4));
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("dec_val", 64'($signed(got[i][15:0])), 64'(dec_ex[i]));

    // channel independence, k=3
    i_sample_interval = 8'd1;
    i_win_log2 = 4'd3;
    step(1'b0, 1'b1, 1'b0, '0);
    got.delete(); gotp.delete();
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b0, 1'b1, pk(1000, -1000));
    idle(4);
    chk("ch_cnt", 64'(got.size()), 64'(8));
    if (got.size() == 8) begin
      chk("ch0_val", 64'($signed(got[7][15:0])), 64'(1000));
      chk("ch1_val", 64'($signed(got[7][31:16])), 64'(-1000));
      chk("ch_prm7", 64'(gotp[7]), 64'(1));
      chk("ch_prm6", 64'(gotp[6]), 64'(0));
    end

    // clear mid-stream with in-flight samples, k 2 -> 1
    i_win_log2 = 4'd2;
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b1, pk(10, 0));
    idle(1);
    chk("pre_clr_prm", 64'(o_primed), 64'(1));
    i_win_log2 = 4'd1;
    step(1'b0, 1'b1, 1'b1, pk(10, 0));
    chk("clr_prm", 64'(o_primed), 64'(0));
    chk("clr_valid", 64'(o_valid), 64'(0));
    i_win_log2 = 4'd3;
    idle(4);
    got.delete(); gotp.delete();
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b0, 1'b1, pk(10, 0));
    idle(4);
    chk("clr_cnt", 64'(got.size()), 64'(2));
    if (got.size() == 2) begin
      chk("clr_v0", 64'($signed(got[0][15:0])), 64'(5));
      chk("clr_v1", 64'($signed(got[1][15:0])), 64'(10));
      chk("clr_p0", 64'(gotp[0]), 64'(0));
      chk("clr_p1", 64'(gotp[1]), 64'(1));
    end

    // max window (requested 15 clamps to 10), random data, N=0
    i_win_log2 = 4'd15;
    i_sample_interval = 8'd0;
    step(1'b0, 1'b1, 1'b0, '0);
    got.delete(); gotp.delete();
    for (int i = 0; i < 3 * (1 << MAXK); i++)
      step(1'b0, 1'b0, 1'b1, PW'($urandom));
    idle(4);
    chk("max_cnt", 64'(got.size()), 64'(3 * (1 << MAXK)));
    chk("max_prm_first", 64'(gotp.size() > 0 ? gotp[(1 << MAXK) - 2] : 1'b1),
        64'(0));
    chk("max_prm", 64'(o_primed), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
